// File: rtl/fft_spi_host.sv
// ---------------------------------------------------------------------------
// fft_spi_host
//
// SPI host (mode 0) that exchanges one fixed-length frame with an FFT
// peripheral.  A start request latches TX_BITS of transmit data, holds the
// peripheral out of frame reset for one setup period, then clocks RX_BITS
// sck periods.  The transmit frame goes out MSB first, followed by zeros for
// the remaining RX_BITS-TX_BITS bits.  The captured frame is published on
// rx_frame_o with a one-cycle done_o pulse.
//
// Parameters
//   TX_BITS  bits shifted out on copi per frame (>= 2)
//   RX_BITS  bits captured from cipo per frame (>= TX_BITS)
//   CLK_DIV  clk cycles per sck half-period (>= 2)
//
// Ports
//   clk_i         system clock, all state changes on its rising edge
//   reset_i       synchronous reset, active low
//   start_i       transfer request, only looked at while idle
//   tx_frame_i    frame to send, MSB first
//   cipo_i        serial data from the peripheral
//   sck_o         SPI clock, idles low
//   copi_o        serial data to the peripheral
//   spi_reset_o   active-high frame reset, high whenever no frame is active
//   rx_frame_o    last complete received frame, first received bit at MSB
//   busy_o        high in every state except IDLE
//   done_o        one-cycle pulse when rx_frame_o has just been updated
// ---------------------------------------------------------------------------
module fft_spi_host #(
  parameter int TX_BITS = 4096,
  parameter int RX_BITS = 8192,
  parameter int CLK_DIV = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [TX_BITS-1:0] tx_frame_i,
  input  logic               cipo_i,
  output logic               sck_o,
  output logic               copi_o,
  output logic               spi_reset_o,
  output logic [RX_BITS-1:0] rx_frame_o,
  output logic               busy_o,
  output logic               done_o
);

  // The bit counter must be able to hold RX_BITS without wrapping.
  localparam int CNT_W = $clog2(RX_BITS + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(RX_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e             state_q;
  logic [DIV_W-1:0]   div_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [TX_BITS-1:0] tx_sh_q;
  logic [RX_BITS-1:0] rx_sh_q;
  logic [RX_BITS-1:0] rx_frame_q;
  logic               sck_q;
  logic               spi_reset_q;
  logic               busy_q;
  logic               done_q;

  logic               div_wrap;
  logic [TX_BITS-1:0] tx_sh_d;
  logic [RX_BITS-1:0] rx_sh_d;
  logic [CNT_W-1:0]   bit_cnt_d;

  // Candidate next values for the shifters and counter; the FSM decides
  // when each one is actually taken.
  always_comb begin
    div_wrap  = (div_q == DIV_LAST);
    tx_sh_d   = {tx_sh_q[TX_BITS-2:0], 1'b0};
    rx_sh_d   = {rx_sh_q[RX_BITS-2:0], cipo_i};
    bit_cnt_d = bit_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_cnt_q   <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_frame_q  <= '0;
      sck_q       <= 1'b0;
      spi_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sck_q       <= 1'b0;
          spi_reset_q <= 1'b1;
          busy_q      <= 1'b0;
          div_q       <= '0;
          bit_cnt_q   <= '0;
          if (start_i) begin
            // The frame is copied here, so later tx_frame_i changes cannot
            // disturb the transfer in flight.
            tx_sh_q     <= tx_frame_i;
            rx_sh_q     <= '0;
            spi_reset_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= SETUP;
          end
        end

        SETUP: begin
          // copi already shows the first TX bit; give the peripheral one
          // full half-period out of reset before the first rising edge.
          if (div_wrap) begin
            div_q   <= '0;
            state_q <= XFER;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        XFER: begin
          if (div_wrap) begin
            div_q <= '0;
            sck_q <= ~sck_q;
            if (!sck_q) begin
              // Rising sck edge: capture the peripheral's bit.
              rx_sh_q <= rx_sh_d;
            end else begin
              // Falling sck edge: present the next TX bit.  Zeros fill in
              // behind the frame, so copi drops to 0 once TX_BITS are out.
              tx_sh_q   <= tx_sh_d;
              bit_cnt_q <= bit_cnt_d;
              if (bit_cnt_q == BIT_LAST) begin
                spi_reset_q <= 1'b1;
                state_q     <= DONE;
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        DONE: begin
          rx_frame_q <= rx_sh_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // After RX_BITS >= TX_BITS shifts the TX register is all zero, so its MSB
  // is also the idle-low copi level outside a frame.
  assign copi_o      = tx_sh_q[TX_BITS-1];
  assign sck_o       = sck_q;
  assign spi_reset_o = spi_reset_q;
  assign rx_frame_o  = rx_frame_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_fft_spi_host.sv
`timescale 1ns/1ps
module tb_fft_spi_host;

  localparam int TXB     = 8;
  localparam int RXB     = 16;
  localparam int LAT2    = 1 + 2 + 2 * 2 * RXB;  // 67
  localparam int LAT3    = 1 + 3 + 2 * 3 * RXB;  // 100
  localparam int PERIOD2 = 68;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, CLK_DIV = 2
  logic           reset_n  = 1'b0;
  logic           start    = 1'b0;
  logic [TXB-1:0] tx_frame = '0;
  logic           cipo     = 1'b0;
  logic           sck, copi, spi_reset, busy, done;
  logic [RXB-1:0] rx_frame;

  // Second instance, CLK_DIV = 3
  logic           start3    = 1'b0;
  logic [TXB-1:0] tx_frame3 = '0;
  logic           cipo3     = 1'b0;
  logic           sck3, copi3, spi_reset3, busy3, done3;
  logic [RXB-1:0] rx_frame3;

  fft_spi_host #(.TX_BITS(TXB), .RX_BITS(RXB), .CLK_DIV(2)) dut (
    .clk_i(clk), .reset_i(reset_n), .start_i(start), .tx_frame_i(tx_frame),
    .cipo_i(cipo), .sck_o(sck), .copi_o(copi), .spi_reset_o(spi_reset),
    .rx_frame_o(rx_frame), .busy_o(busy), .done_o(done)
  );

  fft_spi_host #(.TX_BITS(TXB), .RX_BITS(RXB), .CLK_DIV(3)) dut3 (
    .clk_i(clk), .reset_i(reset_n), .start_i(start3), .tx_frame_i(tx_frame3),
    .cipo_i(cipo3), .sck_o(sck3), .copi_o(copi3), .spi_reset_o(spi_reset3),
    .rx_frame_o(rx_frame3), .busy_o(busy3), .done_o(done3)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Scoreboard
  typedef struct packed {
    logic [TXB-1:0] tx;
    logic [RXB-1:0] rx;
  } exp_t;
  exp_t exp_q[$];
  exp_t exp_cur;

  task automatic push_exp(input logic [TXB-1:0] t, input logic [RXB-1:0] r);
    exp_t x;
    x.tx = t;
    x.rx = r;
    exp_q.push_back(x);
  endtask

  // Peripheral model + monitor for the main instance
  logic [RXB-1:0] resp      = '0;
  logic [RXB-1:0] per_sh    = '0;
  logic [RXB-1:0] copi_bits = '0;
  logic [RXB-1:0] rx_prev   = '0;
  logic           sck_prev  = 1'b0;
  logic           busy_prev = 1'b0;
  logic           done_prev = 1'b0;
  int cyc = 0, start_cyc = 0, done_cnt = 0, busy_rises = 0, rise_cnt = 0;
  int done_cycs[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    // Peripheral: load the response while held in frame reset, shift on
    // every falling sck edge, always present the MSB.
    if (spi_reset === 1'b1) per_sh = resp;
    else if (sck_prev === 1'b1 && sck === 1'b0) per_sh = per_sh << 1;
    if (sck_prev === 1'b0 && sck === 1'b1) begin
      copi_bits = {copi_bits[RXB-2:0], copi};
      rise_cnt++;
    end
    if (busy === 1'b1 && busy_prev === 1'b0) begin
      start_cyc = cyc;
      copi_bits = '0;
      rise_cnt  = 0;
      busy_rises++;
    end
    if (done_prev === 1'b1) check("done_width", done, 0);
    if (done === 1'b1) begin
      done_cnt++;
      done_cycs.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done_pulse required=no_pulse");
      end else begin
        exp_cur = exp_q.pop_front();
        check("rx_frame", rx_frame, exp_cur.rx);
        check("copi_bits", copi_bits, {exp_cur.tx, {(RXB-TXB){1'b0}}});
        check("latency", cyc - start_cyc, LAT2);
        check("spi_reset_at_done", spi_reset, 1);
        $display("frame %0d: tx=%h rx_frame=%h copi=%h latency=%0d",
                 done_cnt, exp_cur.tx, rx_frame, copi_bits, cyc - start_cyc);
      end
    end else if (reset_n === 1'b1 && rx_frame !== rx_prev) begin
      check("rx_frame_hold", rx_frame, rx_prev);
    end
    sck_prev  = sck;
    busy_prev = busy;
    done_prev = done;
    rx_prev   = rx_frame;
    cipo      = per_sh[RXB-1];
  end

  // Monitor for the CLK_DIV=3 instance: phase widths, edge count, latency
  logic           sck3_prev  = 1'b0;
  logic           busy3_prev = 1'b0;
  logic           seen3      = 1'b0;
  logic [RXB-1:0] copi3_bits = '0;
  int cyc3 = 0, start3_cyc = 0, ph_len = 0, rises3 = 0, done3_cnt = 0;

  always @(posedge clk) begin
    #1;
    cyc3++;
    ph_len++;
    if (busy3 === 1'b1 && busy3_prev === 1'b0) begin
      seen3      = 1'b0;
      rises3     = 0;
      ph_len     = 0;
      start3_cyc = cyc3;
      copi3_bits = '0;
    end
    if (reset_n === 1'b1 && busy3 === 1'b1 && sck3 !== sck3_prev) begin
      if (seen3) check("sck3_phase", ph_len, 3);
      seen3  = 1'b1;
      ph_len = 0;
      if (sck3 === 1'b1) begin
        rises3++;
        copi3_bits = {copi3_bits[RXB-2:0], copi3};
      end
    end
    if (done3 === 1'b1) begin
      done3_cnt++;
      check("sck3_rises", rises3, RXB);
      check("latency3", cyc3 - start3_cyc, LAT3);
      check("rx_frame3", rx_frame3, 0);
      check("copi3_bits", copi3_bits, {tx_frame3, {(RXB-TXB){1'b0}}});
      check("spi_reset3_at_done", spi_reset3, 1);
      $display("frame3 %0d: rises=%0d copi=%h latency=%0d", done3_cnt, rises3, copi3_bits, cyc3 - start3_cyc);
    end
    sck3_prev  = sck3;
    busy3_prev = busy3;
  end

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_count", done_cnt, target);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int base;
  int b0;
  int n;
  int nd;

  initial begin
    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sck", sck, 0);
    check("rst_copi", copi, 0);
    check("rst_spi_reset", spi_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx_frame", rx_frame, 0);
    check("rst_sck3", sck3, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic frame; tx_frame changes right after latching
    resp     = 16'h3C96;
    tx_frame = 8'hA5;
    push_exp(8'hA5, 16'h3C96);
    base = done_cnt;
    pulse_start();
    tx_frame = 8'h00;
    wait_done(base + 1, 200);

    // Extra start pulses mid-frame are ignored
    resp     = 16'h5AC3;
    tx_frame = 8'h3E;
    push_exp(8'h3E, 16'h5AC3);
    base = done_cnt;
    pulse_start();
    repeat (4) @(negedge clk);
    start = 1'b1; tx_frame = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(base + 1, 200);
    repeat (80) @(negedge clk);
    check("ignored_start_done_count", done_cnt, base + 1);

    // Reset after the 9th rising sck edge aborts the frame
    resp     = 16'hF00F;
    tx_frame = 8'h81;
    base = done_cnt;
    pulse_start();
    n = 0;
    while (rise_cnt < 9 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_rise9", rise_cnt, 9);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_sck", sck, 0);
    check("abort_copi", copi, 0);
    check("abort_spi_reset", spi_reset, 1);
    check("abort_rx_frame", rx_frame, 0);
    check("abort_done", done, 0);
    reset_n = 1'b1;
    repeat (80) @(negedge clk);
    check("abort_no_done", done_cnt, base);
    check("abort_rx_frame_kept", rx_frame, 0);
    resp     = 16'h1234;
    tx_frame = 8'h7E;
    push_exp(8'h7E, 16'h1234);
    pulse_start();
    wait_done(base + 1, 200);

    // start held high: three back-to-back frames
    resp     = 16'hFFFF;
    tx_frame = 8'hC3;
    push_exp(8'hC3, 16'hFFFF);
    push_exp(8'hC3, 16'hFFFF);
    push_exp(8'hC3, 16'hFFFF);
    base = done_cnt;
    b0   = busy_rises;
    @(negedge clk);
    start = 1'b1;
    n = 0;
    while (busy_rises < b0 + 3 && n < 400) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    wait_done(base + 3, 300);
    nd = done_cycs.size();
    if (nd >= 3) begin
      check("b2b_gap1", done_cycs[nd-2] - done_cycs[nd-3], PERIOD2);
      check("b2b_gap2", done_cycs[nd-1] - done_cycs[nd-2], PERIOD2);
    end
    check("b2b_rx_frame", rx_frame, 16'hFFFF);
    repeat (80) @(negedge clk);
    check("b2b_no_extra_done", done_cnt, base + 3);

    // CLK_DIV = 3 instance
    tx_frame3 = 8'h5A;
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    n = 0;
    while (done3_cnt < 1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done3_count", done3_cnt, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
